data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and completion signals between the core data side and the data-memory responder.
interface data_mem_responder_if #(
   parameter int unsigned DATA_W = 16
);
   logic              mem_read;
   logic              mem_write;
   logic [15:0]       addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output mem_read, mem_write, addr, write_data,
      input  read_data, busy, done, err
   );

   modport slave (
      input  mem_read, mem_write, addr, write_data,
      output read_data, busy, done, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle done/err completion pulse.
// Requests are latched at capture; the access happens on the edge that enters DONE.
module data_mem_responder #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave io_bus
);
   localparam int unsigned AW    = 16;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_capture;
   logic              w_access;

   logic              r_op_rd;
   logic              r_op_wr;
   logic [AW-1:0]     r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_rd;
   logic              w_wr;
   logic [AW-1:0]     w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_reject;

   // With zero wait states the access happens on the capture edge, so use live inputs in IDLE
   assign w_rd     = (r_state == S_IDLE) ? io_bus.mem_read   : r_op_rd;
   assign w_wr     = (r_state == S_IDLE) ? io_bus.mem_write  : r_op_wr;
   assign w_addr   = (r_state == S_IDLE) ? io_bus.addr       : r_addr;
   assign w_wdata  = (r_state == S_IDLE) ? io_bus.write_data : r_wdata;
   assign w_reject = (w_rd & w_wr) | (|w_addr[AW-1:ADDR_W]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      w_access     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.mem_read | io_bus.mem_write) begin
               w_capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_state_next = S_DONE;
                  w_access     = 1'b1;
               end else begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = CNT_W'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
               w_state_next = S_DONE;
               w_access     = 1'b1;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_rd <= 1'b0;
         r_op_wr <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_capture) begin
            r_op_rd <= io_bus.mem_read;
            r_op_wr <= io_bus.mem_write;
            r_addr  <= io_bus.addr;
            r_wdata <= io_bus.write_data;
         end
         if (w_access) begin
            if (w_reject) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end else begin
               if (w_rd) r_rdata <= r_mem[w_addr[ADDR_W-1:0]];
               r_err <= 1'b0;
            end
         end
      end
   end

   // Storage array; cleared on reset so an aborted store leaves no trace
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_access && w_wr && !w_reject) begin
         r_mem[w_addr[ADDR_W-1:0]] <= w_wdata;
      end
   end

   assign io_bus.read_data = r_rdata;
   assign io_bus.err       = r_err;
   assign io_bus.busy      = (r_state != S_IDLE);
   assign io_bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: vector table on a 2-wait-state instance plus hand sequences for
// field changes while busy, reset mid-access and zero-wait back-to-back stores.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   data_mem_responder_if #(.DATA_W(16)) bus_a ();
   data_mem_responder_if #(.DATA_W(16)) bus_b ();

   data_mem_responder #(.DATA_W(16), .ADDR_W(3), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .io_bus(bus_a));
   data_mem_responder #(.DATA_W(16), .ADDR_W(3), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .io_bus(bus_b));

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t        vecs [13];
   logic [15:0] exp_mem [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access on the 2-wait-state instance; optionally disturbs inputs while busy
   task automatic access_a(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic scramble,
                           input logic exp_err, input logic [15:0] exp_rdata,
                           input string name);
      int lat;
      @(negedge clk);
      bus_a.mem_read   = rd;
      bus_a.mem_write  = wr;
      bus_a.addr       = addr;
      bus_a.write_data = wdata;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      chk({name, " busy"}, 32'(bus_a.busy), 32'd1);
      if (scramble) begin
         bus_a.addr       = addr ^ 16'h0002;
         bus_a.write_data = ~wdata;
         bus_a.mem_read   = 1'b1;
      end else begin
         bus_a.mem_read  = 1'b0;
         bus_a.mem_write = 1'b0;
      end
      while (!bus_a.done && lat < 20) begin
         @(negedge clk);
         lat++;
         bus_a.mem_read  = 1'b0;
         bus_a.mem_write = 1'b0;
      end
      chk({name, " latency"}, 32'(lat), 32'd3);
      chk({name, " err"}, 32'(bus_a.err), 32'(exp_err));
      chk({name, " rdata"}, 32'(bus_a.read_data), 32'(exp_rdata));
      @(negedge clk);
      chk({name, " done pulse width"}, 32'(bus_a.done), 32'd0);
      chk({name, " idle"}, 32'(bus_a.busy), 32'd0);
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
      vecs[2]  = '{1'b1, 1'b0, 16'h0008, 16'h0000, 1'b1, 16'h0000};
      vecs[3]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
      vecs[4]  = '{1'b1, 1'b1, 16'h0002, 16'h1234, 1'b1, 16'h0000};
      vecs[5]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000};
      vecs[6]  = '{1'b0, 1'b1, 16'h0007, 16'hCAFE, 1'b0, 16'h0000};
      vecs[7]  = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'hCAFE};
      vecs[8]  = '{1'b0, 1'b1, 16'h8003, 16'h5555, 1'b1, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001};
      vecs[12] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
      exp_mem = '{16'h0001, 16'h0000, 16'h0000, 16'h0000,
                  16'h0000, 16'hBEEF, 16'h0000, 16'hCAFE};

      bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.addr = '0; bus_a.write_data = '0;
      bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.addr = '0; bus_b.write_data = '0;

      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus_a.busy), 32'd0);
      chk("reset done", 32'(bus_a.done), 32'd0);
      chk("reset err", 32'(bus_a.err), 32'd0);
      chk("reset rdata", 32'(bus_a.read_data), 32'd0);
      chk("reset busy b", 32'(bus_b.busy), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++)
         access_a(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                  vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

      // Every word after the rejected accesses
      for (int i = 0; i < 8; i++)
         access_a(1'b1, 1'b0, 16'(i), 16'h0000, 1'b0, 1'b0, exp_mem[i],
                  $sformatf("sweep%0d", i));

      // Inputs changed during WAIT must not affect the latched store
      access_a(1'b0, 1'b1, 16'h0004, 16'h1111, 1'b1, 1'b0, 16'hCAFE, "latched store");
      access_a(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 16'h1111, "latched load4");
      access_a(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'h0000, "latched load6");

      // Reset asserted in WAIT of a store
      access_a(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, "pre-reset load");
      @(negedge clk);
      bus_a.mem_write  = 1'b1;
      bus_a.addr       = 16'h0003;
      bus_a.write_data = 16'hAAAA;
      @(posedge clk);
      @(negedge clk);
      bus_a.mem_write = 1'b0;
      chk("abort busy before", 32'(bus_a.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort busy", 32'(bus_a.busy), 32'd0);
      chk("abort done", 32'(bus_a.done), 32'd0);
      chk("abort rdata", 32'(bus_a.read_data), 32'd0);
      chk("abort err", 32'(bus_a.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      access_a(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, "post-abort load3");
      access_a(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, "post-abort load5");

      // Zero wait states: strobe held, one store every two cycles
      pulses = 0;
      @(negedge clk);
      bus_b.mem_write  = 1'b1;
      bus_b.addr       = 16'h0000;
      bus_b.write_data = 16'h00A0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_b.done) pulses++;
         chk($sformatf("b2b done%0d", i), 32'(bus_b.done), 32'd1);
         chk($sformatf("b2b err%0d", i), 32'(bus_b.err), 32'd0);
         bus_b.addr       = 16'(i + 1);
         bus_b.write_data = 16'(16'h00A0 + i + 1);
         if (i == 7) bus_b.mem_write = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b2b gap%0d", i), 32'(bus_b.busy), 32'd0);
      end
      chk("b2b pulse count", 32'(pulses), 32'd8);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("rb idle%0d", i), 32'(bus_b.done), 32'd0);
         bus_b.mem_read = 1'b1;
         bus_b.addr     = 16'(i);
         @(posedge clk);
         @(negedge clk);
         bus_b.mem_read = 1'b0;
         chk($sformatf("rb done%0d", i), 32'(bus_b.done), 32'd1);
         chk($sformatf("rb data%0d", i), 32'(bus_b.read_data), 32'(16'h00A0 + i));
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
